// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector and stall/flush controller for a 5-stage RV32 pipeline.
// Keeps a shadow of the ID/EX load fields and saturating stall/flush event counters.
module hazard_stall_unit #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       ifid_op_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             id_memread_i,
    input  logic [4:0]       id_rd_i,
    input  logic             branch_taken_i,
    output logic             NoOP_o,
    output logic             PCWrite_o,
    output logic             Stall_o,
    output logic             Flush_o,
    output logic             ex_memread_o,
    output logic [4:0]       ex_rd_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0]       BubbleInit = 3'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e           state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic             ex_memread_q, ex_memread_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic use_rs1, use_rs2, hz;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (ifid_op_i)
            OpReg, OpStore, OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpImm, OpLoad: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hz = ex_memread_q && (ex_rd_q != 5'd0) &&
                ((use_rs1 && (ifid_rs1_i == ex_rd_q)) || (use_rs2 && (ifid_rs2_i == ex_rd_q)));

    // Outputs are forced to their idle values while reset is held, without waiting for an edge.
    always_comb begin
        state_d   = state_q;
        bub_d     = bub_q;
        NoOP_o    = 1'b0;
        PCWrite_o = 1'b1;
        Stall_o   = 1'b0;
        Flush_o   = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                StRun: begin
                    if (hz) begin
                        NoOP_o    = 1'b1;
                        PCWrite_o = 1'b0;
                        Stall_o   = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StStall;
                            bub_d   = BubbleInit;
                        end
                    end else begin
                        Flush_o = branch_taken_i;
                    end
                end
                StStall: begin
                    NoOP_o    = 1'b1;
                    PCWrite_o = 1'b0;
                    Stall_o   = 1'b1;
                    bub_d     = bub_q - 3'd1;
                    if (bub_q == 3'd1) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        ex_memread_d = NoOP_o ? 1'b0 : id_memread_i;
        ex_rd_d      = NoOP_o ? 5'd0 : id_rd_i;
        stall_cnt_d  = (NoOP_o && (stall_cnt_q != CntMax)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d  = (Flush_o && (flush_cnt_q != CntMax)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StRun;
            bub_q        <= 3'd0;
            ex_memread_q <= 1'b0;
            ex_rd_q      <= 5'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            bub_q        <= bub_d;
            ex_memread_q <= ex_memread_d;
            ex_rd_q      <= ex_rd_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_memread_o = ex_memread_q;
    assign ex_rd_o      = ex_rd_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4)
// share stimulus; each directed vector names the instance whose outputs it predicts.
module tb_hazard_stall_unit;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op  = OP_I;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       mr  = 1'b0, br = 1'b0;

    logic        n0, p0, s0, f0, m0, n1, p1, s1, f1, m1, n2, p2, s2, f2, m2;
    logic [4:0]  r0, r1, r2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    always #5 clk = ~clk;

    hazard_stall_unit #(.LOAD_LAT(1), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .ifid_op_i(op), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
        .id_memread_i(mr), .id_rd_i(rd), .branch_taken_i(br),
        .NoOP_o(n0), .PCWrite_o(p0), .Stall_o(s0), .Flush_o(f0),
        .ex_memread_o(m0), .ex_rd_o(r0), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    hazard_stall_unit #(.LOAD_LAT(3), .CNT_W(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .ifid_op_i(op), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
        .id_memread_i(mr), .id_rd_i(rd), .branch_taken_i(br),
        .NoOP_o(n1), .PCWrite_o(p1), .Stall_o(s1), .Flush_o(f1),
        .ex_memread_o(m1), .ex_rd_o(r1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    hazard_stall_unit #(.LOAD_LAT(1), .CNT_W(4)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .ifid_op_i(op), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
        .id_memread_i(mr), .id_rd_i(rd), .branch_taken_i(br),
        .NoOP_o(n2), .PCWrite_o(p2), .Stall_o(s2), .Flush_o(f2),
        .ex_memread_o(m2), .ex_rd_o(r2), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    // Packed view: {NoOP, PCWrite, Stall, Flush, ex_memread, ex_rd[4:0], stall_cnt[15:0], flush_cnt[15:0]}
    typedef struct {
        int          id;
        int          sel;
        logic [41:0] exp;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    stepn = 0;

    function automatic logic [41:0] pk(input logic n, p, s, f, m, input logic [4:0] r,
                                       input int sc, input int fc);
        return {n, p, s, f, m, r, 16'(sc), 16'(fc)};
    endfunction

    function automatic logic [41:0] nrm(input logic m, input logic [4:0] r, input int sc, fc);
        return pk(1'b0, 1'b1, 1'b0, 1'b0, m, r, sc, fc);
    endfunction

    function automatic logic [41:0] bub(input logic m, input logic [4:0] r, input int sc, fc);
        return pk(1'b1, 1'b0, 1'b1, 1'b0, m, r, sc, fc);
    endfunction

    function automatic logic [41:0] flu(input logic m, input logic [4:0] r, input int sc, fc);
        return pk(1'b0, 1'b1, 1'b0, 1'b1, m, r, sc, fc);
    endfunction

    // Drive one IF/ID cycle just after the rising edge and predict the outputs for that cycle.
    task automatic step(input int sel, input logic [6:0] o, input logic [4:0] a, b,
                        input logic m, input logic [4:0] d, input logic t, input logic r,
                        input logic [41:0] e);
        item_t it;
        @(posedge clk);
        #1;
        op = o; rs1 = a; rs2 = b; mr = m; rd = d; br = t; rst = r;
        stepn++;
        it.id = stepn; it.sel = sel; it.exp = e;
        sb.push_back(it);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t       it;
            logic [41:0] act;
            it = sb.pop_front();
            case (it.sel)
                0:       act = {n0, p0, s0, f0, m0, r0, sc0, fc0};
                1:       act = {n1, p1, s1, f1, m1, r1, sc1, fc1};
                default: act = {n2, p2, s2, f2, m2, r2, 12'd0, sc2, 12'd0, fc2};
            endcase
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL step%0d dut%0d got n/p/s/f=%b%b%b%b exmr=%b exrd=%0d sc=%0d fc=%0d want n/p/s/f=%b%b%b%b exmr=%b exrd=%0d sc=%0d fc=%0d",
                         it.id, it.sel, act[41], act[40], act[39], act[38], act[37],
                         act[36:32], act[31:16], act[15:0], it.exp[41], it.exp[40],
                         it.exp[39], it.exp[38], it.exp[37], it.exp[36:32],
                         it.exp[31:16], it.exp[15:0]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // LOAD_LAT=1 instance
        step(0, OP_LD,  5'd1,  5'd0,  1, 5'd5,  0, 0, nrm(0, 5'd0,  0, 0)); // lw x5
        step(0, OP_R,   5'd5,  5'd1,  0, 5'd6,  0, 0, bub(1, 5'd5,  0, 0)); // add x6,x5,x1
        step(0, OP_R,   5'd5,  5'd1,  0, 5'd6,  0, 0, nrm(0, 5'd0,  1, 0)); // held add proceeds
        step(0, OP_I,   5'd0,  5'd0,  0, 5'd0,  0, 0, nrm(0, 5'd6,  1, 0));
        step(0, OP_LD,  5'd2,  5'd0,  1, 5'd0,  0, 0, nrm(0, 5'd0,  1, 0)); // lw x0
        step(0, OP_R,   5'd0,  5'd0,  0, 5'd1,  0, 0, nrm(1, 5'd0,  1, 0)); // add x1,x0,x0
        step(0, OP_LD,  5'd2,  5'd0,  1, 5'd5,  0, 0, nrm(0, 5'd1,  1, 0)); // lw x5
        step(0, OP_JAL, 5'd5,  5'd5,  0, 5'd1,  0, 0, nrm(1, 5'd5,  1, 0)); // jal, fields alias x5
        step(0, OP_BR,  5'd3,  5'd4,  0, 5'd0,  1, 0, flu(0, 5'd1,  1, 0)); // beq taken
        step(0, OP_I,   5'd0,  5'd0,  0, 5'd0,  0, 0, nrm(0, 5'd0,  1, 1));
        step(0, OP_LD,  5'd1,  5'd0,  1, 5'd4,  0, 0, nrm(0, 5'd0,  1, 1)); // lw x4
        step(0, OP_BR,  5'd4,  5'd3,  0, 5'd0,  1, 0, bub(1, 5'd4,  1, 1)); // beq x4,x3 taken
        step(0, OP_BR,  5'd4,  5'd3,  0, 5'd0,  1, 0, flu(0, 5'd0,  2, 1));
        step(0, OP_LD,  5'd1,  5'd0,  1, 5'd9,  0, 0, nrm(0, 5'd0,  2, 2)); // lw x9
        step(0, OP_R,   5'd9,  5'd9,  0, 5'd10, 0, 0, bub(1, 5'd9,  2, 2)); // rs1==rs2==x9
        step(0, OP_R,   5'd9,  5'd9,  0, 5'd10, 0, 0, nrm(0, 5'd0,  3, 2));
        step(0, OP_LD,  5'd1,  5'd0,  1, 5'd11, 0, 0, nrm(0, 5'd10, 3, 2)); // lw x11
        step(0, OP_LD,  5'd11, 5'd0,  1, 5'd12, 0, 0, bub(1, 5'd11, 3, 2)); // lw x12,0(x11)
        step(0, OP_LD,  5'd11, 5'd0,  1, 5'd12, 0, 0, nrm(0, 5'd0,  4, 2));
        step(0, OP_R,   5'd12, 5'd0,  0, 5'd13, 0, 0, bub(1, 5'd12, 4, 2)); // add x13,x12,x0
        step(0, OP_R,   5'd12, 5'd0,  0, 5'd13, 0, 0, nrm(0, 5'd0,  5, 2));
        step(0, OP_LD,  5'd1,  5'd0,  1, 5'd5,  0, 0, nrm(0, 5'd13, 5, 2)); // lw x5
        step(0, OP_R,   5'd5,  5'd1,  0, 5'd6,  0, 1, nrm(0, 5'd0,  0, 0)); // async reset

        // LOAD_LAT=3 instance
        step(1, OP_I,   5'd0,  5'd0,  0, 5'd0,  0, 0, nrm(0, 5'd0,  0, 0));
        step(1, OP_LD,  5'd2,  5'd0,  1, 5'd7,  0, 0, nrm(0, 5'd0,  0, 0)); // lw x7
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  0, 0, bub(1, 5'd7,  0, 0)); // sw x7,0(x2)
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  0, 0, bub(0, 5'd0,  1, 0));
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  0, 0, bub(0, 5'd0,  2, 0));
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  0, 0, nrm(0, 5'd0,  3, 0)); // back in RUN
        step(1, OP_LD,  5'd2,  5'd0,  1, 5'd7,  0, 0, nrm(0, 5'd0,  3, 0));
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  0, 0, bub(1, 5'd7,  3, 0));
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  1, 0, bub(0, 5'd0,  4, 0)); // branch ignored
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  0, 1, nrm(0, 5'd0,  0, 0)); // reset mid-stall
        step(1, OP_ST,  5'd2,  5'd7,  0, 5'd0,  0, 0, nrm(0, 5'd0,  0, 0)); // resumed in RUN

        // CNT_W=4 instance: stall counter saturates at 15
        for (int k = 0; k < 20; k++) begin
            int s;
            s = (k < 15) ? k : 15;
            step(2, OP_LD, 5'd1, 5'd0, 1, 5'd5, 0, 0, nrm(0, 5'd0, s, 0));
            step(2, OP_R,  5'd5, 5'd1, 0, 5'd6, 0, 0, bub(1, 5'd5, s, 0));
        end
        step(2, OP_I, 5'd0, 5'd0, 0, 5'd0, 0, 0, nrm(0, 5'd0, 15, 0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Sequential producer of the NoOP input consumed by the ID-stage control decoder.
- Also drives PC write-enable, IF/ID hold and IF/ID flush for the 5-stage RV32 pipeline.
- Owns a shadow of the ID/EX load/destination fields and detects load-use hazards.
- Inserts LOAD_LAT bubbles per hazard and flushes IF/ID on a taken beq; keeps saturating stall/flush event counters.

Parameters:
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7)
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- ifid_op_i  input  7  opcode field of the instruction in IF/ID
- ifid_rs1_i  input  5  rs1 field of the instruction in IF/ID
- ifid_rs2_i  input  5  rs2 field of the instruction in IF/ID
- id_memread_i  input  1  MemRead output of the ID-stage decoder
- id_rd_i  input  5  rd field of the instruction in IF/ID
- branch_taken_i  input  1  ID-stage beq compare taken
- NoOP_o  output  1  forces the decoder to emit all-zero controls
- PCWrite_o  output  1  PC register enable
- Stall_o  output  1  IF/ID hold
- Flush_o  output  1  IF/ID clear next edge
- ex_memread_o  output  1  shadow ID/EX MemRead
- ex_rd_o  output  5  shadow ID/EX rd
- stall_cnt_o  output  CNT_W  bubbles inserted, saturating
- flush_cnt_o  output  CNT_W  flushes issued, saturating

Behaviour:
- Reset (async, rst_i=1):
  - State RUN; shadow regs 0; bubble counter 0; event counters 0.
  - Outputs: NoOP_o=0, PCWrite_o=1, Stall_o=0, Flush_o=0.
- Shadow regs, each edge:
  - If NoOP_o: ex_memread<=0, ex_rd<=0.
  - Else: ex_memread<=id_memread_i, ex_rd<=id_rd_i.
- Source use by opcode:
  - rs1 used for 0110011, 0010011, 0000011, 0100011, 1100011.
  - rs2 used for 0110011, 0100011, 1100011.
  - Any other opcode uses neither source.
- hz = ex_memread && ex_rd!=0 && ((use_rs1 && rs1==ex_rd) || (use_rs2 && rs2==ex_rd)). Combinational, same cycle.
- FSM RUN:
  - If hz: NoOP_o=1, PCWrite_o=0, Stall_o=1, Flush_o=0.
  - If hz and LOAD_LAT>1: load bubble counter with LOAD_LAT-1 and go to STALL.
  - Else: NoOP_o=0, PCWrite_o=1, Stall_o=0, Flush_o=branch_taken_i.
- FSM STALL:
  - NoOP_o=1, PCWrite_o=0, Stall_o=1, Flush_o=0.
  - Decrement the bubble counter each edge; return to RUN on the edge where it is 1.
  - Residual hazard is re-evaluated in RUN.
- Priority: stall beats flush. A taken branch during a bubble is ignored; the branch re-evaluates after the stall, when its operands are valid.
- Latency:
  - Hazard to first bubble is 0 cycles (combinational).
  - Total bubbles per isolated load-use = LOAD_LAT.
- Counters:
  - stall_cnt increments on every edge with NoOP_o=1.
  - flush_cnt increments on every edge with Flush_o=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Boundaries:
  - rd=x0 never stalls.
  - rs1==rs2==ex_rd counts as one hazard.
  - Back-to-back load-use chains stall independently.
  - Reset mid-STALL returns to RUN immediately; outputs take reset values asynchronously.

Test Plan:
- Reset: rst_i=1 mid-run -> NoOP_o=0, PCWrite_o=1, Stall_o=0, Flush_o=0, counters 0 without a clock edge.
- LOAD_LAT=1, lw x5 then add x6,x5,x1 -> exactly one cycle NoOP_o=1/PCWrite_o=0/Stall_o=1; stall_cnt_o=1; ex_memread_o=0 on the bubble.
- LOAD_LAT=3, lw x7 then sw x7,0(x2) (rs2 hit) -> 3 consecutive bubble cycles; stall_cnt_o=3; back to RUN on the 4th cycle.
- lw x0 then add x1,x0,x0 -> no stall; lw x5 then an op with opcode 1101111 and rs1 field=5 -> no stall.
- beq taken with no hazard -> Flush_o=1 for one cycle, flush_cnt_o=1. lw x4 then beq x4,x3 taken -> bubble first with Flush_o=0, then Flush_o=1 next cycle.
- CNT_W=4, hazard forced 20 times -> stall_cnt_o holds at 15.
